qcore_port_in_fifo: RTL
=======================

# qcore_port_in_fifo

Input-port responder for the qick processor core. It time-stamps and buffers external 32-bit samples, then presents the oldest entry as a 64-bit input-port word. The core samples that word with its port-read strobe, and the read pops the entry. It sits between an external data source and one slot of the core's `port_dt_i[]` array, and drives the core's `flag_i` condition.

## Interface
Parameters:
- `FIFO_AW`, 3: log2 of FIFO depth; depth = 2^FIFO_AW entries.
- `PADDR_W`, 4: width of the core port address.
- `PORT_ADDR`, 0: port address this instance answers to.

Ports:
- `c_clk_i` in 1: core clock; the only clock.
- `c_rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous flush, tied to core restart.
- `time_i` in 32: current core time, sampled at push.
- `in_vld_i` in 1: external sample valid, one push per cycle.
- `in_dt_i` in 32: external sample data.
- `in_rdy_o` out 1: not full (informative only; no backpressure).
- `port_re_i` in 1: core port-read strobe.
- `port_addr_i` in PADDR_W: core port address qualifying `port_re_i`.
- `port_dt_o` out 64: head entry {time[31:0], data[31:0]}; 0 when empty.
- `flag_o` out 1: FIFO not empty.
- `level_o` out FIFO_AW+1: current occupancy, 0..2^FIFO_AW.
- `ovf_o` out 1: sticky, a push was dropped because the FIFO was full.
- `udf_o` out 1: sticky, an addressed read was issued while the FIFO was empty.

## Operation
- **Storage:** 2^FIFO_AW × 64-bit array. Write and read pointers are FIFO_AW+1 bits, with the MSB used as the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- **Push:** requires `in_vld_i` and (not full, or a pop in the same cycle). Stores {`time_i`, `in_dt_i`} and increments the write pointer modulo 2^(FIFO_AW+1).
- **Drop:** `in_vld_i` while full with no same-cycle pop. The entry is discarded and `ovf_o` is set.
- **Addressed read:** `port_re_i` and `port_addr_i == PORT_ADDR`.
  - If not empty: pop, and increment the read pointer.
  - If empty: no pop, set `udf_o`; `port_dt_o` stays 0.
- `port_re_i` with any other address is ignored.
- **Show-ahead:** `port_dt_o` always holds the current head entry. The core captures it in the same cycle it asserts `port_re_i`.
- **Outputs:** `flag_o` = not empty; `in_rdy_o` = not full; `level_o` = write pointer − read pointer (FIFO_AW+1-bit subtraction).
- **Clear:** `clear_i` zeroes both pointers, `ovf_o`, `udf_o` and `port_dt_o`. It has priority over a push or pop in the same cycle; both are ignored. Array contents need not be cleared.
- **Reset values:** `port_dt_o`=0, `flag_o`=0, `in_rdy_o`=1, `level_o`=0, `ovf_o`=0, `udf_o`=0.

## Timing
- All outputs are registered or derived from registered pointers. There is no combinational path from inputs to outputs.
- **Push latency:** push at cycle N into an empty FIFO → `flag_o`=1, `port_dt_o`=entry and `level_o`=1 at N+1.
- **Pop latency:** pop at cycle N → next head on `port_dt_o` at N+1, or 0 if now empty, with `flag_o` falling at N+1.
- **Simultaneous push and pop:**
  - Not empty: both occur; level unchanged.
  - Full: both occur; no `ovf_o`.
  - Empty: push occurs; `udf_o` is set; the pushed entry appears at N+1.
- Back-to-back pops every cycle are supported. Each cycle presents the next entry.
- **Pointer wrap-around:** seamless. Ordering is preserved across many multiples of the depth.
- **Reset mid-operation:** `c_rst_ni` low forces all reset values immediately (asynchronous). Operation resumes on the first clock edge after deassertion.

## Test plan
- **Fill and drain.** Default params; push data 1..8 with time 100..107, then 8 addressed reads at consecutive cycles.
  - `port_dt_o` sequence is {100,1} .. {107,8}.
  - `level_o` goes 8→0; `flag_o` falls after the last read; `ovf_o`=`udf_o`=0.
- **Overflow.** Push 9 entries with no reads.
  - 9th entry is dropped; `ovf_o`=1; `level_o`=8; `in_rdy_o`=0.
  - Drain returns entries 1..8 only.
- **Full simultaneous push/pop.** Full FIFO; push 0xAA while an addressed read is issued the same cycle.
  - Entry 1 is popped and 0xAA accepted; `level_o` stays 8; `ovf_o`=0.
  - 0xAA is the last entry drained.
- **Address filter and underflow.**
  - Read with `port_addr_i`=PORT_ADDR+1 → no change.
  - Addressed read while empty → `udf_o`=1, `port_dt_o`=0.
  - `clear_i` → `udf_o`=0.
- **Wrap-around.** 40 interleaved push/pop pairs at random levels 0..8.
  - Output order matches a scoreboard.
  - `level_o` matches the model every cycle.
- **Asynchronous reset.** Assert `c_rst_ni`=0 mid-stream, between clock edges, at level 5.
  - Outputs go to reset values before the next edge.
  - After release, first push of 0x55 at time 7 gives `port_dt_o`={7,0x55} one cycle later.

Source files
------------

// File: rtl/qcore_port_in_fifo.sv
// Time-stamping input FIFO answering one port address of the qick core.
// Head entry is pre-registered so the core sees it on the same cycle it strobes a read.
module qcore_port_in_fifo #(
    parameter int FIFO_AW   = 3,
    parameter int PADDR_W   = 4,
    parameter int PORT_ADDR = 0
) (
    input  logic               c_clk_i,
    input  logic               c_rst_ni,
    input  logic               clear_i,
    input  logic [31:0]        time_i,
    input  logic               in_vld_i,
    input  logic [31:0]        in_dt_i,
    output logic               in_rdy_o,
    input  logic               port_re_i,
    input  logic [PADDR_W-1:0] port_addr_i,
    output logic [63:0]        port_dt_o,
    output logic               flag_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               ovf_o,
    output logic               udf_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PTR_W = FIFO_AW + 1;
    localparam logic [PADDR_W-1:0] MY_ADDR = PADDR_W'(PORT_ADDR);

    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_nxt, rd_nxt;
    logic             empty, full;
    logic             hit, pop, push, drop, miss;

    assign in_entry = '{stamp: time_i, data: in_dt_i};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                   (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);

    assign hit  = port_re_i && (port_addr_i == MY_ADDR);
    assign pop  = hit && !empty;
    assign miss = hit && empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign push = in_vld_i && (!full || pop);
    assign drop = in_vld_i && full && !pop;

    assign wr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign rd_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Next head: bypass the incoming entry when it lands exactly where the head will be.
    always_comb begin
        head_nxt = '0;
        if (wr_nxt != rd_nxt) begin
            if (push && (rd_nxt == wr_ptr))
                head_nxt = in_entry;
            else
                head_nxt = mem[rd_nxt[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge c_clk_i) begin
        if (push && !clear_i)
            mem[wr_ptr[FIFO_AW-1:0]] <= in_entry;
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_o     <= 1'b0;
            udf_o     <= 1'b0;
            port_dt_o <= '0;
        end else if (clear_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_o     <= 1'b0;
            udf_o     <= 1'b0;
            port_dt_o <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            port_dt_o <= head_nxt;
            if (drop) ovf_o <= 1'b1;
            if (miss) udf_o <= 1'b1;
        end
    end

    assign flag_o   = !empty;
    assign in_rdy_o = !full;
    assign level_o  = wr_ptr - rd_ptr;

endmodule
